vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: CPU_WINDOW, default 4, CPU ownership window length in cycles.
REQ-002 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: cpu_req  in  1  CPU addresses VRAM (0x4000-0x5FFF) this cycle.
REQ-005 Port: cpu_we  in  1  CPU write strobe (CPU mem_load).
REQ-006 Port: cpu_addr  in  13  CPU VRAM word address (mem_address[12:0]).
REQ-007 Port: cpu_wdata  in  16  CPU write data.
REQ-008 Port: cpu_rdata  out  16  CPU read data.
REQ-009 Port: cpu_busy  out  1  VRAM not owned by CPU (drives CPU mem_busy).
REQ-010 Port: vid_req  in  1  scanout fetch request, level, held until vid_valid.
REQ-011 Port: vid_addr  in  13  scanout word address, stable while vid_req high.
REQ-012 Port: vid_rdata  out  16  registered scanout data.
REQ-013 Port: vid_valid  out  1  one-cycle pulse, vid_rdata valid, acknowledges vid_req.
REQ-014 Port: ram_addr / ram_wdata / ram_we  out  13/16/1  single-port synchronous VRAM, 1-cycle read latency.
REQ-015 Port: ram_rdata  in  16  VRAM read data.

Function
REQ-016 States: IDLE, VID_ADDR, VID_DATA, CPU_HOLD; 2-bit window counter cnt; 1-bit last_vid flag.
REQ-017 IDLE: vid_req and not (last_vid and cpu_req) -> VID_ADDR, last_vid<=1; else cpu_req -> CPU_HOLD, cnt<=0, last_vid<=0; else stay.
REQ-018 Arbitration: video wins ties unless previous grant was video and CPU is pending (alternation, no starvation either side).
REQ-019 VID_ADDR: ram_addr=vid_addr, ram_we=0; always -> VID_DATA next cycle.
REQ-020 VID_DATA: vid_rdata<=ram_rdata at end of cycle, vid_valid=1 in following cycle only; -> IDLE.
REQ-021 CPU_HOLD: cpu_busy=0, ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we, cpu_rdata=ram_rdata (combinational); cnt increments each cycle; cnt==CPU_WINDOW-1 -> IDLE.
REQ-022 Window is fixed length; cpu_req dropping mid-window does not shorten it; ram_we is forced 0 outside CPU_HOLD.
REQ-023 cpu_busy=1 in every state except CPU_HOLD; CPU read data is valid in window cycles 1..CPU_WINDOW-1 (CPU counts 2 cycles after busy low, samples in cycle 3).
REQ-024 vid_valid asserted no later than 8 cycles after vid_req rises with CPU_WINDOW=4.
REQ-025 Outside VID_ADDR/CPU_HOLD, ram_addr holds last driven value; ram_wdata don't-care.
REQ-026 vid_req falling before vid_valid is a protocol violation; arbiter completes the started fetch regardless.

Reset
REQ-027 reset low asynchronously forces state=IDLE, cnt=0, last_vid=0, vid_rdata=0, vid_valid=0, ram_addr=0, ram_we=0, cpu_busy=1.
REQ-028 Reset mid-CPU_HOLD aborts window immediately, no further ram_we; reset mid-fetch drops the fetch, no vid_valid.
REQ-029 First grant evaluated on first rising edge after reset deasserts.

Structure
REQ-030 Shared package vram_pkg holds state encoding, VRAM_AW=13, VRAM_DW=16, VRAM_BASE=0x4000, CPU_WINDOW default.
REQ-031 No sub-module; VRAM primitive instantiated by the top level, arbiter drives its ports.

Verification
REQ-032 Idle, cpu_req=1 cpu_we=1 addr 0x0010 data 0xBEEF -> cpu_busy low next cycle for 4 cycles, single ram_we with addr 0x0010; later read returns 0xBEEF in window cycle 1.
REQ-033 vid_req=1 addr 0x0100 (RAM holds 0x1234), no CPU -> vid_valid pulses exactly once 3 cycles later, vid_rdata=0x1234.
REQ-034 vid_req and cpu_req rise together -> video granted first, CPU window starts immediately after vid fetch; repeat -> grants alternate V,C,V,C.
REQ-035 vid_req rises in CPU_HOLD cnt=0 -> vid_valid within 8 cycles, cpu_busy high during fetch.
REQ-036 reset low during CPU_HOLD cnt=1 with cpu_we=1 -> ram_we=0 and cpu_busy=1 same cycle, state IDLE after release.
REQ-037 Continuous vid_req and cpu_req for 200 cycles -> no starvation, each side granted ≥1 per 9 cycles, no ram_we outside CPU_HOLD.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared VRAM geometry and arbiter state encoding.
// Latency: n/a; backpressure: n/a.
package vram_pkg;

    localparam int          VRAM_AW        = 13;
    localparam int          VRAM_DW        = 16;
    localparam logic [15:0] VRAM_BASE      = 16'h4000;
    localparam int          CPU_WINDOW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VID_ADDR = 2'd1,
        ST_VID_DATA = 2'd2,
        ST_CPU_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Shares one synchronous single-port VRAM between CPU and scanout; video fetch = 3 cycles to vid_valid.
// Latency: CPU owns RAM for a fixed CPU_WINDOW cycles; backpressure: cpu_busy stalls CPU, vid_req is held until vid_valid.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int CPU_WINDOW = CPU_WINDOW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [VRAM_AW-1:0]   cpu_addr,
    input  logic [VRAM_DW-1:0]   cpu_wdata,
    output logic [VRAM_DW-1:0]   cpu_rdata,
    output logic                 cpu_busy,
    input  logic                 vid_req,
    input  logic [VRAM_AW-1:0]   vid_addr,
    output logic [VRAM_DW-1:0]   vid_rdata,
    output logic                 vid_valid,
    output logic [VRAM_AW-1:0]   ram_addr,
    output logic [VRAM_DW-1:0]   ram_wdata,
    output logic                 ram_we,
    input  logic [VRAM_DW-1:0]   ram_rdata
);

    localparam logic [1:0] LP_CNT_LAST = 2'(CPU_WINDOW - 1);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_cnt;
    logic                 r_last_vid;
    logic [VRAM_DW-1:0]   r_vid_rdata;
    logic                 r_vid_valid;
    logic [VRAM_AW-1:0]   r_addr_hold;
    logic [VRAM_AW-1:0]   w_ram_addr;
    logic                 w_vid_go;

    // vid_req is still high in the vid_valid cycle; masking it there stops a
    // duplicate fetch of the request that is just being acknowledged.
    assign w_vid_go = vid_req && !r_vid_valid && !(r_last_vid && cpu_req);

    always_comb begin
        w_next     = r_state;
        w_ram_addr = r_addr_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_vid_go)
                    w_next = ST_VID_ADDR;
                else if (cpu_req)
                    w_next = ST_CPU_HOLD;
            end
            ST_VID_ADDR: begin
                w_ram_addr = vid_addr;
                w_next     = ST_VID_DATA;
            end
            ST_VID_DATA: begin
                w_next = ST_IDLE;
            end
            ST_CPU_HOLD: begin
                w_ram_addr = cpu_addr;
                if (r_cnt == LP_CNT_LAST)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_last_vid  <= 1'b0;
            r_vid_rdata <= '0;
            r_vid_valid <= 1'b0;
            r_addr_hold <= '0;
        end else begin
            r_state     <= w_next;
            r_addr_hold <= w_ram_addr;
            r_vid_valid <= (r_state == ST_VID_DATA);
            if (r_state == ST_VID_DATA)
                r_vid_rdata <= ram_rdata;
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_VID_ADDR) begin
                        r_last_vid <= 1'b1;
                    end else if (w_next == ST_CPU_HOLD) begin
                        r_cnt      <= 2'd0;
                        r_last_vid <= 1'b0;
                    end
                end
                ST_CPU_HOLD: r_cnt <= r_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    // Write strobe qualified by state so a stalled CPU can never write.
    assign ram_we    = (r_state == ST_CPU_HOLD) && cpu_we;
    assign ram_addr  = w_ram_addr;
    assign ram_wdata = cpu_wdata;
    assign cpu_busy  = (r_state != ST_CPU_HOLD);
    assign cpu_rdata = ram_rdata;
    assign vid_rdata = r_vid_rdata;
    assign vid_valid = r_vid_valid;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural VRAM and a video-data scoreboard.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cpu_req, cpu_we, vid_req;
    logic [12:0] cpu_addr, vid_addr, ram_addr;
    logic [15:0] cpu_wdata, cpu_rdata, vid_rdata, ram_wdata, ram_rdata;
    logic        cpu_busy, vid_valid, ram_we;

    vram_arbiter #(.CPU_WINDOW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_busy  (cpu_busy),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_rdata (vid_rdata),
        .vid_valid (vid_valid),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    // Synchronous single-port VRAM, read-first, preloaded while reset is low.
    logic [15:0] mem [0:8191];
    always @(posedge clk) begin
        if (!reset) begin
            mem[13'h100] <= 16'h1234;
            mem[13'h200] <= 16'hA5A5;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    int          checks = 0, errors = 0, cyc = 0;
    int          vid_pulses = 0, we_cnt = 0, we_outside = 0;
    logic [12:0] last_we_addr = '0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;
    int          g_kind [$];
    int          g_cyc  [$];
    logic        busy_d = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (reset === 1'b1) begin
            if (vid_valid === 1'b1) begin
                vid_pulses++;
                g_kind.push_back(1);
                g_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL vid_unexpected: vid_valid with rdata %h, nothing expected", vid_rdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (vid_rdata !== exp_v) begin
                        errors++;
                        $display("FAIL vid_rdata: got %h expected %h", vid_rdata, exp_v);
                    end
                end
            end
            if (busy_d && cpu_busy === 1'b0) begin
                g_kind.push_back(2);
                g_cyc.push_back(cyc);
            end
            if (ram_we === 1'b1) begin
                we_cnt++;
                last_we_addr = ram_addr;
                if (cpu_busy !== 1'b0) we_outside++;
            end
        end
        busy_d = cpu_busy;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vid(output int lat);
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (vid_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL vid_timeout: no vid_valid within 16 cycles");
        end
    endtask

    task automatic wait_busy_low(output int lat);
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cpu_busy === 1'b0) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat, n, we0, p0, start, maxv, maxc, nv, nc, lastv, lastc;
        logic bh [0:15];
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cpu_busy", cpu_busy, 1);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_vid_rdata", vid_rdata, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        tick(); reset = 1'b1;

        // Lone video fetch: valid 3 cycles after request, exactly one pulse
        tick(); vid_req = 1'b1; vid_addr = 13'h100; exp_q.push_back(16'h1234);
        wait_vid(lat);
        chk("vid_lat_idle", lat, 3);
        tick(); vid_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("vid_single_pulse", vid_pulses, 1);

        // CPU write 0xBEEF to 0x0010
        tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h10; cpu_wdata = 16'hBEEF; we0 = we_cnt;
        wait_busy_low(lat);
        chk("cpu_grant_lat", lat, 1);
        tick(); cpu_we = 1'b0; cpu_req = 1'b0;
        n = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cpu_busy === 1'b1) break;
            n++;
        end
        chk("cpu_window_len", n, 4);
        chk("cpu_we_count", we_cnt - we0, 1);
        chk("cpu_we_addr", last_we_addr, 13'h10);
        chk("ram_content", mem[13'h10], 16'hBEEF);

        // CPU read back, data valid in window cycle 1
        tick(); cpu_req = 1'b1; cpu_addr = 13'h10;
        wait_busy_low(lat);
        @(negedge clk);
        chk("cpu_rdata_w1", cpu_rdata, 16'hBEEF);
        tick(); cpu_req = 1'b0;
        repeat (5) tick();

        // Simultaneous requests then continuous contention for 200 cycles
        g_kind.delete(); g_cyc.delete();
        tick(); vid_req = 1'b1; vid_addr = 13'h200; cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 13'h400; cpu_wdata = 16'h7777; start = cyc;
        n = 0;
        while (cyc - start < 200) begin
            exp_q.push_back(16'hA5A5);
            wait_vid(lat);
            if (n == 0) chk("tie_vid_first_lat", lat, 3);
            else        chk("vid_lat_le8", (lat >= 0 && lat <= 8), 1);
            n++;
            if (lat < 0) break;
        end
        tick(); vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (8) tick();
        chk("alt_g0_vid", g_kind[0], 1);
        chk("alt_g1_cpu", g_kind[1], 2);
        chk("alt_g2_vid", g_kind[2], 1);
        chk("alt_g3_cpu", g_kind[3], 2);
        chk("cpu_after_vid_gap", g_cyc[1] - g_cyc[0], 1);
        maxv = 0; maxc = 0; nv = 0; nc = 0; lastv = -1; lastc = -1;
        for (int i = 0; i < g_kind.size(); i++) begin
            if (g_kind[i] == 1) begin
                if (lastv >= 0 && g_cyc[i] - lastv > maxv) maxv = g_cyc[i] - lastv;
                lastv = g_cyc[i]; nv++;
            end else begin
                if (lastc >= 0 && g_cyc[i] - lastc > maxc) maxc = g_cyc[i] - lastc;
                lastc = g_cyc[i]; nc++;
            end
        end
        chk("vid_max_gap_le9", (maxv > 0 && maxv <= 9), 1);
        chk("cpu_max_gap_le9", (maxc > 0 && maxc <= 9), 1);
        chk("vid_grants_ge20", (nv >= 20), 1);
        chk("cpu_grants_ge20", (nc >= 20), 1);
        chk("we_outside_hold", we_outside, 0);

        // Video request arriving in CPU window cycle 0
        tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0;
        tick(); vid_req = 1'b1; vid_addr = 13'h100; exp_q.push_back(16'h1234); cpu_req = 1'b0;
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bh[k] = cpu_busy;
            if (vid_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("mid_window_cnt0", bh[0], 0);
        chk("vid_in_window_le8", (lat >= 0 && lat <= 8), 1);
        chk("busy_during_fetch", (lat >= 2) ? (bh[lat-1] & bh[lat-2]) : 1'b0, 1);
        tick(); vid_req = 1'b0;
        repeat (3) tick();

        // Reset during CPU window cycle 1 with write pending
        tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h20; cpu_wdata = 16'h1111;
        tick();
        tick();
        @(negedge clk);
        chk("pre_rst_we_cnt1", ram_we, 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_we", ram_we, 0);
        chk("rst_mid_busy", cpu_busy, 1);
        chk("rst_mid_addr", ram_addr, 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick(); tick(); reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", cpu_busy, 1);
        tick(); vid_req = 1'b1; vid_addr = 13'h200; exp_q.push_back(16'hA5A5);
        wait_vid(lat);
        chk("post_rst_idle_lat", lat, 3);
        tick(); vid_req = 1'b0;
        repeat (2) tick();

        // Reset during a fetch drops it silently
        tick(); vid_req = 1'b1; vid_addr = 13'h100;
        tick(); reset = 1'b0; vid_req = 1'b0; p0 = vid_pulses;
        tick(); tick(); reset = 1'b1;
        repeat (6) tick();
        chk("fetch_dropped_by_rst", vid_pulses - p0, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
